// File: rtl/alu_pkg.sv
// Opcode encodings and request records shared by the ALU issue path.
package alu_pkg;

    localparam logic [3:0] ALU_OP_ADD     = 4'h0;
    localparam logic [3:0] ALU_OP_SUB     = 4'h1;
    localparam logic [3:0] ALU_OP_SHL     = 4'h2;
    localparam logic [3:0] ALU_OP_SHR     = 4'h3;
    localparam logic [3:0] ALU_OP_PASS_R  = 4'h4;
    localparam logic [3:0] ALU_OP_PASS_RW = 4'h5;
    localparam logic [3:0] ALU_OP_AND     = 4'h6;
    localparam logic [3:0] ALU_OP_OR      = 4'h7;
    localparam logic [3:0] ALU_OP_XOR     = 4'h8;
    localparam logic [3:0] ALU_OP_PACK    = 4'h9;
    localparam logic [3:0] ALU_OP_LAST    = 4'h9;

    localparam int ALU_TAG_W = 4;

    // Operand fields only; the issue unit carries its own parameterised tag alongside.
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] in_r;
        logic [31:0] in_rw;
    } alu_operands_t;

    typedef struct packed {
        logic [3:0]           op;
        logic [31:0]          in_r;
        logic [31:0]          in_rw;
        logic [ALU_TAG_W-1:0] tag;
    } alu_req_t;

endpackage

// File: rtl/ALU.sv
// Combinational ALU core: in_r is the primary operand, in_rw the second operand / shift amount.
module ALU
    import alu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] in_r,
    input  logic [31:0] in_rw,
    output logic [31:0] out,
    output logic        is_zero
);

    logic shift_oob;

    assign shift_oob = |in_rw[31:5];

    always_comb begin
        out = '0;
        case (op)
            ALU_OP_ADD:     out = in_r + in_rw;
            ALU_OP_SUB:     out = in_r - in_rw;
            ALU_OP_SHL:     out = shift_oob ? '0 : (in_r << in_rw[4:0]);
            ALU_OP_SHR:     out = shift_oob ? '0 : (in_r >> in_rw[4:0]);
            ALU_OP_PASS_R:  out = in_r;
            ALU_OP_PASS_RW: out = in_rw;
            ALU_OP_AND:     out = in_r & in_rw;
            ALU_OP_OR:      out = in_r | in_rw;
            ALU_OP_XOR:     out = in_r ^ in_rw;
            ALU_OP_PACK:    out = {16'h0000, in_r[7:0], in_rw[7:0]};
            default:        out = '0;
        endcase
    end

    assign is_zero = (out == '0);

endmodule

// File: rtl/alu_req_fifo.sv
// Synchronous DEPTH x WIDTH request FIFO; pointers wrap naturally as DEPTH is a power of two.
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != FULL_CNT);
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/alu_issue_unit.sv
// Buffers tagged ALU requests, issues one per cycle into the ALU and holds the result
// in a registered response slot; also tracks the zero flag of the last legal op.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_in_r,
    input  logic [31:0]      req_in_rw,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_out,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             flag_zero,
    output logic             busy
);

    localparam int PW = TAG_W + $bits(alu_operands_t);

    logic [PW-1:0]          fifo_wr_data, fifo_rd_data;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    alu_operands_t          head_ops;
    logic [TAG_W-1:0]       head_tag;
    logic [31:0]            alu_out;
    logic                   alu_zero;
    logic                   issue, legal;

    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_out_q, rsp_out_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             flag_zero_q, flag_zero_d;

    assign req_ready    = !fifo_full;
    assign fifo_push    = req_valid && !fifo_full;
    assign fifo_wr_data = {req_tag, req_op, req_in_r, req_in_rw};
    assign fifo_pop     = issue;

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PW)
    ) u_fifo (
        .clk_i     (clk),
        .reset_i   (reset),
        .push_i    (fifo_push),
        .pop_i     (fifo_pop),
        .wr_data_i (fifo_wr_data),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign {head_tag, head_ops} = fifo_rd_data;

    ALU u_alu (
        .op      (head_ops.op),
        .in_r    (head_ops.in_r),
        .in_rw   (head_ops.in_rw),
        .out     (alu_out),
        .is_zero (alu_zero)
    );

    // Illegal opcodes are screened here so the ALU's undefined-op output never reaches the slot.
    assign legal = (head_ops.op <= ALU_OP_LAST);
    assign issue = !fifo_empty && (!rsp_valid_q || rsp_ready);

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_out_d   = rsp_out_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;
        rsp_tag_d   = rsp_tag_q;
        flag_zero_d = flag_zero_q;
        if (issue) begin
            rsp_valid_d = 1'b1;
            rsp_out_d   = legal ? alu_out : '0;
            rsp_zero_d  = legal && alu_zero;
            rsp_err_d   = !legal;
            rsp_tag_d   = head_tag;
            if (legal) flag_zero_d = alu_zero;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tag_q   <= '0;
            flag_zero_q <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_out_q   <= rsp_out_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tag_q   <= rsp_tag_d;
            flag_zero_q <= flag_zero_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_tag   = rsp_tag_q;
    assign flag_zero = flag_zero_q;
    assign busy      = (fifo_count != '0) || rsp_valid_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: driver predicts responses, monitor compares on handshake.
`timescale 1ns/1ps
module tb_alu_issue_unit;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_op = 4'h0;
    logic [31:0]      req_in_r = 32'h0;
    logic [31:0]      req_in_rw = 32'h0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_out;
    logic             rsp_zero;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    logic             flag_zero;
    logic             busy;

    alu_issue_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_in_r  (req_in_r),
        .req_in_rw (req_in_rw),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err),
        .rsp_tag   (rsp_tag),
        .flag_zero (flag_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      out;
        logic             zero;
        logic             err;
        logic [TAG_W-1:0] tag;
        logic             flag;
    } exp_t;

    exp_t     exp_q[$];
    exp_t     mon_e;
    int       checks = 0;
    int       errors = 0;
    logic     model_flag = 1'b0;
    int       n, w, run;
    logic     done;
    alu_req_t rq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // Architectural result of one opcode, straight from the opcode list.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] r,
                                               input logic [31:0] rw);
        case (op)
            4'h0:    return r + rw;
            4'h1:    return r - rw;
            4'h2:    return r << rw;
            4'h3:    return r >> rw;
            4'h4:    return r;
            4'h5:    return rw;
            4'h6:    return r & rw;
            4'h7:    return r | rw;
            4'h8:    return r ^ rw;
            4'h9:    return (r % 256) * 256 + (rw % 256);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_push(input logic [3:0] op, input logic [31:0] r, input logic [31:0] rw,
                              input logic [TAG_W-1:0] tag);
        exp_t e;
        logic legal;
        legal  = (op < 4'd10);
        e.out  = legal ? ref_result(op, r, rw) : 32'h0;
        e.zero = legal && (e.out == 32'h0);
        e.err  = !legal;
        e.tag  = tag;
        if (legal) model_flag = e.zero;
        e.flag = model_flag;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [31:0] r, input logic [31:0] rw,
                        input logic [TAG_W-1:0] tag);
        int waited;
        waited    = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_in_r  = r;
        req_in_rw = rw;
        req_tag   = tag;
        while (!req_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: got req_ready=0 for %0d cycles want 1", waited);
            req_valid = 1'b0;
            return;
        end
        model_push(op, r, rw, tag);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding want 0", exp_q.size());
        end
    endtask

    task automatic check_reset(input string name);
        chk(name, 64'({req_ready, rsp_valid, rsp_zero, rsp_err, flag_zero, busy, rsp_tag, rsp_out}),
            64'({1'b1, 5'b0, 4'h0, 32'h0}));
    endtask

    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got tag %h out %h want no response", rsp_tag, rsp_out);
            end else if (rsp_ready) begin
                mon_e = exp_q.pop_front();
                chk("rsp", 64'({rsp_out, rsp_zero, rsp_err, rsp_tag, flag_zero}),
                    64'({mon_e.out, mon_e.zero, mon_e.err, mon_e.tag, mon_e.flag}));
            end else begin
                mon_e = exp_q[0];
                chk("rsp_hold", 64'({rsp_out, rsp_zero, rsp_err, rsp_tag, flag_zero}),
                    64'({mon_e.out, mon_e.zero, mon_e.err, mon_e.tag, mon_e.flag}));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_values");
        reset     = 1'b0;
        rsp_ready = 1'b1;

        // First op: latency and fields
        send(4'h0, 32'd5, 32'd7, 4'd3);
        chk("no_bypass", 64'(rsp_valid), 64'(0));
        @(posedge clk); #1;
        chk("latency_valid", 64'(rsp_valid), 64'(1));
        chk("first_rsp", 64'({rsp_out, rsp_zero, rsp_tag, flag_zero}), 64'({32'd12, 1'b0, 4'd3, 1'b0}));
        drain();

        // Zero result then illegal opcode leaves flag alone
        send(4'h1, 32'd9, 32'd9, 4'd4);
        send(4'hC, 32'd1, 32'd2, 4'd5);
        drain();
        chk("flag_after_err", 64'(flag_zero), 64'(1));

        // Back-pressure fill
        rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++)
            send(4'($urandom_range(0, 9)), $urandom, 32'($urandom_range(0, 40)), 4'(i + 6));
        chk("full_ready_low", 64'(req_ready), 64'(0));
        chk("full_busy", 64'(busy), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("hold_tag", 64'(rsp_tag), 64'(6));
        rsp_ready = 1'b1;
        n = 0;
        while (rsp_valid && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("burst_len", 64'(n), 64'(DEPTH + 1));
        drain();

        // Back-to-back stream
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send(4'($urandom_range(0, 9)), $urandom, 32'($urandom_range(0, 40)), 4'(i));
            end
            begin
                w   = 0;
                run = 0;
                while (!rsp_valid && w < 50) begin
                    @(posedge clk); #1;
                    w++;
                end
                while (rsp_valid && run < 40) begin
                    run++;
                    @(posedge clk); #1;
                end
                chk("stream_run", 64'(run), 64'(16));
            end
        join
        drain();

        // Byte pack and oversize shift
        send(4'h9, 32'h0000_1234, 32'h0000_ABCD, 4'd1);
        send(4'h2, 32'hFFFF_FFFF, 32'd32, 4'd2);
        drain();
        chk("flag_shl32", 64'(flag_zero), 64'(1));

        // Randomised traffic with random back-pressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    rq.op    = 4'($urandom_range(0, 15));
                    rq.in_rw = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                    rq.in_r  = ($urandom_range(0, 3) == 0) ? rq.in_rw : $urandom;
                    rq.tag   = 4'($urandom_range(0, 15));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send(rq.op, rq.in_r, rq.in_rw, rq.tag);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                rsp_ready = 1'b1;
            end
        join
        drain();

        // Reset with queued work and a pending response
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(4'h4, 32'(i + 1), 32'h0, 4'(12 + i));
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset("mid_reset");
        exp_q.delete();
        model_flag = 1'b0;
        reset      = 1'b0;
        rsp_ready  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_reset_idle", 64'({rsp_valid, busy}), 64'(0));
        send(4'h0, 32'd1, 32'd1, 4'd9);
        drain();
        chk("flag_after_reset", 64'(flag_zero), 64'(0));

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
